// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage behind the ALU logic units.
// Captures each ALU result with carry/overflow, derives N/Z, and hands the
// beat to writeback through a valid/ready handshake backed by a 2-entry skid
// buffer. Also keeps a sticky overflow flag and a wrapping retire counter.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   ALU side handshake (in_ready is registered)
//   Result, Cin, Vin      ALU result word, carry-out, signed overflow
//   out_valid / out_ready writeback side handshake
//   out_result, out_flags registered result and its {N,Z,C,V}
//   sticky_v, sticky_clr  sticky overflow flag and its clear
//   retired_cnt           wrapping count of retired results
module alu_result_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Result,
  input  logic             Cin,
  input  logic             Vin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             sticky_v,
  input  logic             sticky_clr,
  output logic [CNTW-1:0]  retired_cnt
);

  localparam int unsigned FW = 4;

  // State encodes how many entries are held (output entry first, then skid).
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [WIDTH-1:0]  out_result_q;
  logic [FW-1:0]     out_flags_q;
  logic [WIDTH-1:0]  skid_result_q;
  logic [FW-1:0]     skid_flags_q;
  logic              sticky_q, sticky_d;
  logic [CNTW-1:0]   cnt_q;

  logic              in_xfer;
  logic              out_xfer;
  logic [FW-1:0]     new_flags;
  logic              load_out_new;
  logic              load_skid;
  logic              move_skid;

  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid_q & out_ready;
  // {N,Z,C,V} of the incoming beat, computed once at capture.
  assign new_flags = {Result[WIDTH-1], (Result == '0), Cin, Vin};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (in_xfer) state_d = S_ONE;
      S_ONE: begin
        if (in_xfer && !out_xfer)      state_d = S_FULL;
        else if (!in_xfer && out_xfer) state_d = S_EMPTY;
        else                           state_d = S_ONE;
      end
      S_FULL:  if (out_xfer) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
  end

  // Datapath load controls derived from the current state and transfers.
  always_comb begin
    load_out_new = 1'b0;
    load_skid    = 1'b0;
    move_skid    = 1'b0;
    unique case (state_q)
      S_EMPTY: load_out_new = in_xfer;
      S_ONE: begin
        load_out_new = in_xfer & out_xfer;
        load_skid    = in_xfer & ~out_xfer;
      end
      S_FULL:  move_skid = out_xfer;
      default: ;
    endcase
  end

  // Set wins over clear when a V=1 result retires in the clearing cycle.
  always_comb begin
    sticky_d = sticky_q;
    if (out_xfer && out_flags_q[0]) sticky_d = 1'b1;
    else if (sticky_clr)            sticky_d = 1'b0;
  end

  // Entry registers, registered handshake outputs, sticky flag and counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_flags_q   <= '0;
      skid_result_q <= '0;
      skid_flags_q  <= '0;
      sticky_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      in_ready_q  <= (state_d != S_FULL);
      out_valid_q <= (state_d != S_EMPTY);
      if (load_out_new) begin
        out_result_q <= Result;
        out_flags_q  <= new_flags;
      end else if (move_skid) begin
        out_result_q <= skid_result_q;
        out_flags_q  <= skid_flags_q;
      end
      if (load_skid) begin
        skid_result_q <= Result;
        skid_flags_q  <= new_flags;
      end
      sticky_q <= sticky_d;
      if (out_xfer) cnt_q <= cnt_q + CNTW'(1);
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_flags   = out_flags_q;
  assign sticky_v    = sticky_q;
  assign retired_cnt = cnt_q;

endmodule
